// File: rtl/tele_tx_ser_pkg.sv
// tele_tx_ser_pkg: shared tele FSM state encoding and line constants
package tele_tx_ser_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tele_state_t;
  localparam logic TELE_LINE_IDLE = 1'b1;
endpackage

// File: rtl/tele_tx_ser_baud_tick.sv
// tele_baud_tick: bit-period counter producing a bit_end pulse every BASE_DIV<<div_sel_q cycles
module tele_baud_tick #(
  parameter int BASE_DIV = 2
) (
  input  logic       src_clk,
  input  logic       rst_src_n,
  input  logic       clear,
  input  logic [1:0] div_sel_q,
  output logic       bit_end
);
  localparam int CW = $clog2(BASE_DIV * 8);
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  assign last    = CW'((BASE_DIV << div_sel_q) - 1);
  assign bit_end = cnt == last;
  // count 0..P-1 and wrap; clear holds the phase at zero until a frame starts
  always_ff @(posedge src_clk or negedge rst_src_n)
    if (!rst_src_n) cnt <= '0;
    else cnt <= (clear || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/tele_tx_ser.sv
// tele_tx_ser: framed serial transmitter (start, LSB-first data, optional parity, stop bits)
module tele_tx_ser
  import tele_tx_ser_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BASE_DIV   = 2,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              src_clk,
  input  logic              rst_src_n,
  input  logic [1:0]        div_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              tx_busy,
  output logic              frame_done
);
  localparam int IW = $clog2(DATA_W + 1);
  tele_state_t       state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [1:0]        dsel_q, dsel_nxt;
  logic              par_q, par_nxt;
  logic              line_nxt;
  logic              bit_end;
  logic              accept;
  assign tx_ready   = state == ST_IDLE;
  assign tx_busy    = ~tx_ready;
  assign accept     = tx_valid & tx_ready;
  assign frame_done = (state == ST_STOP) && bit_end && (idx == IW'(STOP_BITS - 1));
  tele_baud_tick #(.BASE_DIV(BASE_DIV)) u_tick (
    .src_clk  (src_clk),
    .rst_src_n(rst_src_n),
    .clear    (tx_ready),
    .div_sel_q(dsel_q),
    .bit_end  (bit_end)
  );
  // frame sequencing; the line level is derived from the next state so it leaves a register
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    dsel_nxt  = dsel_q;
    par_nxt   = par_q;
    case (state)
      ST_IDLE: if (accept) begin
        state_nxt = ST_START;
        shreg_nxt = tx_data;
        dsel_nxt  = div_sel;
        par_nxt   = (^tx_data) ^ (PARITY_ODD != 0);
      end
      ST_START: if (bit_end) begin
        state_nxt = ST_DATA;
        idx_nxt   = '0;
      end
      ST_DATA: if (bit_end) begin
        shreg_nxt = shreg >> 1;
        idx_nxt   = idx + 1'b1;
        if (idx == IW'(DATA_W - 1)) begin
          state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          idx_nxt   = '0;
        end
      end
      ST_PARITY: if (bit_end) begin
        state_nxt = ST_STOP;
        idx_nxt   = '0;
      end
      ST_STOP: if (bit_end) begin
        if (idx == IW'(STOP_BITS - 1)) state_nxt = ST_IDLE;
        else idx_nxt = idx + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    line_nxt = (state_nxt == ST_START)  ? 1'b0 :
               (state_nxt == ST_DATA)   ? shreg_nxt[0] :
               (state_nxt == ST_PARITY) ? par_q : TELE_LINE_IDLE;
  end
  // state, datapath and line registers; reset abandons any frame and idles the line
  always_ff @(posedge src_clk or negedge rst_src_n)
    if (!rst_src_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      idx     <= '0;
      dsel_q  <= '0;
      par_q   <= 1'b0;
      tx_line <= TELE_LINE_IDLE;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      idx     <= idx_nxt;
      dsel_q  <= dsel_nxt;
      par_q   <= par_nxt;
      tx_line <= line_nxt;
    end
endmodule
